// File: rtl/gpu_cmd_loader.sv
//==============================================================================
// Module   : gpu_cmd_loader
// Purpose  : Decodes a 32-bit PS command stream into double-buffered sprite GPU
//            settings plus a BRAM burst write port. Optional macro
//            GPU_CMD_LOADER_AUTOSWAP_EN swaps shadow->active on every frame.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module gpu_cmd_loader #(
    parameter int NR_OF_BLOBS   = 4,
    parameter int ram_add_width = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [31:0]                          cmd_data,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic                                 v_sync,
    input  logic                                 err_clr,
    output logic [11:0]                          background,
    output logic [NR_OF_BLOBS-1:0]               sprite_enable,
    output logic [10*NR_OF_BLOBS-1:0]            y1_pos,
    output logic [10*NR_OF_BLOBS-1:0]            x1_pos,
    output logic [10*NR_OF_BLOBS-1:0]            y2_pos,
    output logic [10*NR_OF_BLOBS-1:0]            x2_pos,
    output logic [ram_add_width*NR_OF_BLOBS-1:0] ram_address,
    output logic [2*NR_OF_BLOBS-1:0]             layer,
    output logic [ram_add_width-1:0]             wr_add,
    output logic [11:0]                          wr_data,
    output logic                                 wr_req,
    output logic                                 commit_pending,
    output logic                                 err
);

    localparam logic [3:0] c_OP_BG     = 4'h1;
    localparam logic [3:0] c_OP_RECT   = 4'h2;
    localparam logic [3:0] c_OP_ATTR   = 4'h3;
    localparam logic [3:0] c_OP_BURST  = 4'h4;
    localparam logic [3:0] c_OP_COMMIT = 4'h5;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RECT2       = 2'd1,
        BURST       = 2'd2,
        WAIT_COMMIT = 2'd3
    } state_t;

    state_t r_state, w_next;

    logic                     r_vsync;
    logic [ram_add_width-1:0] r_ptr;
    logic [11:0]              r_cnt;
    logic [3:0]               r_rect_idx;
    logic                     r_rect_ok;

    logic [11:0]              r_sh_bg;
    logic                     r_sh_en [NR_OF_BLOBS];
    logic [9:0]               r_sh_y1 [NR_OF_BLOBS];
    logic [9:0]               r_sh_x1 [NR_OF_BLOBS];
    logic [9:0]               r_sh_y2 [NR_OF_BLOBS];
    logic [9:0]               r_sh_x2 [NR_OF_BLOBS];
    logic [ram_add_width-1:0] r_sh_ra [NR_OF_BLOBS];
    logic [1:0]               r_sh_ly [NR_OF_BLOBS];

    logic       w_fb, w_accept, w_idx_ok, w_swap;
    logic [3:0] w_op, w_idx;
    logic       w_ld_bg, w_ld_rect1, w_ld_rect2, w_ld_attr, w_rect_cmd;
    logic       w_start_burst, w_do_wr, w_set_err;
    logic       w_unused_bits;

    assign w_fb          = r_vsync & ~v_sync;
    assign cmd_ready     = (r_state != WAIT_COMMIT);
    assign commit_pending = (r_state == WAIT_COMMIT);
    assign w_accept      = cmd_valid & cmd_ready;
    assign w_op          = cmd_data[31:28];
    assign w_idx         = cmd_data[27:24];
    assign w_idx_ok      = ({1'b0, w_idx} < 5'(NR_OF_BLOBS));
    assign w_unused_bits = cmd_data[22];

`ifdef GPU_CMD_LOADER_AUTOSWAP_EN
    assign w_swap = w_fb;
`else
    assign w_swap = w_fb && (r_state == WAIT_COMMIT);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_vsync <= 1'b1;
        end else begin
            r_state <= w_next;
            r_vsync <= v_sync;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_ld_bg       = 1'b0;
        w_ld_rect1    = 1'b0;
        w_ld_rect2    = 1'b0;
        w_ld_attr     = 1'b0;
        w_rect_cmd    = 1'b0;
        w_start_burst = 1'b0;
        w_do_wr       = 1'b0;
        w_set_err     = 1'b0;
        case (r_state)
            IDLE: if (w_accept) begin
                case (w_op)
                    c_OP_BG:     w_ld_bg = 1'b1;
                    c_OP_RECT: begin
                        w_rect_cmd = 1'b1;
                        w_ld_rect1 = w_idx_ok;
                        w_set_err  = ~w_idx_ok;
                        w_next     = RECT2;
                    end
                    c_OP_ATTR: begin
                        w_ld_attr = w_idx_ok;
                        w_set_err = ~w_idx_ok;
                    end
                    c_OP_BURST: if (cmd_data[27:16] != 12'd0) begin
                        w_start_burst = 1'b1;
                        w_next        = BURST;
                    end
                    c_OP_COMMIT: w_next = WAIT_COMMIT;
                    default:     w_set_err = 1'b1;
                endcase
            end
            RECT2: if (w_accept) begin
                // Second rectangle word is pure data; its opcode bits are ignored.
                w_ld_rect2 = r_rect_ok;
                w_next     = IDLE;
            end
            BURST: if (w_accept) begin
                w_do_wr = 1'b1;
                if (r_cnt == 12'd1) w_next = IDLE;
            end
            WAIT_COMMIT: if (w_fb) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sh_bg    <= '0;
            r_rect_idx <= '0;
            r_rect_ok  <= 1'b0;
            for (int i = 0; i < NR_OF_BLOBS; i++) begin
                r_sh_en[i] <= 1'b0;
                r_sh_y1[i] <= '0;
                r_sh_x1[i] <= '0;
                r_sh_y2[i] <= '0;
                r_sh_x2[i] <= '0;
                r_sh_ra[i] <= '0;
                r_sh_ly[i] <= '0;
            end
        end else begin
            if (w_ld_bg) r_sh_bg <= cmd_data[11:0];
            if (w_rect_cmd) begin
                r_rect_idx <= w_idx;
                r_rect_ok  <= w_idx_ok;
            end
            for (int i = 0; i < NR_OF_BLOBS; i++) begin
                if (w_ld_rect1 && w_idx == 4'(i)) begin
                    r_sh_y1[i] <= cmd_data[19:10];
                    r_sh_x1[i] <= cmd_data[9:0];
                end
                if (w_ld_rect2 && r_rect_idx == 4'(i)) begin
                    r_sh_y2[i] <= cmd_data[19:10];
                    r_sh_x2[i] <= cmd_data[9:0];
                end
                if (w_ld_attr && w_idx == 4'(i)) begin
                    r_sh_en[i] <= cmd_data[23];
                    r_sh_ly[i] <= cmd_data[21:20];
                    r_sh_ra[i] <= cmd_data[ram_add_width-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            background    <= '0;
            sprite_enable <= '0;
            y1_pos        <= '0;
            x1_pos        <= '0;
            y2_pos        <= '0;
            x2_pos        <= '0;
            ram_address   <= '0;
            layer         <= '0;
        end else if (w_swap) begin
            background <= r_sh_bg;
            for (int i = 0; i < NR_OF_BLOBS; i++) begin
                sprite_enable[i]                           <= r_sh_en[i];
                y1_pos[i*10 +: 10]                         <= r_sh_y1[i];
                x1_pos[i*10 +: 10]                         <= r_sh_x1[i];
                y2_pos[i*10 +: 10]                         <= r_sh_y2[i];
                x2_pos[i*10 +: 10]                         <= r_sh_x2[i];
                ram_address[i*ram_add_width +: ram_add_width] <= r_sh_ra[i];
                layer[i*2 +: 2]                            <= r_sh_ly[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_req  <= 1'b0;
            wr_add  <= '0;
            wr_data <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            wr_req <= w_do_wr;
            if (w_start_burst) begin
                r_ptr <= cmd_data[ram_add_width-1:0];
                r_cnt <= cmd_data[27:16];
            end else if (w_do_wr) begin
                wr_add  <= r_ptr;
                wr_data <= cmd_data[11:0];
                r_ptr   <= r_ptr + 1'b1;
                r_cnt   <= r_cnt - 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)          err <= 1'b0;
        else if (w_set_err)  err <= 1'b1;
        else if (err_clr)    err <= 1'b0;
    end

endmodule

`default_nettype wire

// File: tb/tb_gpu_cmd_loader.sv
//==============================================================================
// Module   : tb_gpu_cmd_loader
// Purpose  : Scoreboard bench for gpu_cmd_loader with a word-level command model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gpu_cmd_loader;

    localparam int NB = 4;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [31:0]     cmd_data = '0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            v_sync = 1'b1;
    logic            err_clr = 1'b0;
    logic [11:0]     background;
    logic [NB-1:0]   sprite_enable;
    logic [10*NB-1:0] y1_pos, x1_pos, y2_pos, x2_pos;
    logic [AW*NB-1:0] ram_address;
    logic [2*NB-1:0] layer;
    logic [AW-1:0]   wr_add;
    logic [11:0]     wr_data;
    logic            wr_req, commit_pending, err;

    gpu_cmd_loader #(.NR_OF_BLOBS(NB), .ram_add_width(AW)) dut (
        .clk(clk), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .v_sync(v_sync), .err_clr(err_clr),
        .background(background), .sprite_enable(sprite_enable),
        .y1_pos(y1_pos), .x1_pos(x1_pos), .y2_pos(y2_pos), .x2_pos(x2_pos),
        .ram_address(ram_address), .layer(layer), .wr_add(wr_add),
        .wr_data(wr_data), .wr_req(wr_req), .commit_pending(commit_pending), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bg;
        logic [NB-1:0] en;
        logic [9:0]  y1 [NB];
        logic [9:0]  x1 [NB];
        logic [9:0]  y2 [NB];
        logic [9:0]  x2 [NB];
        logic [AW-1:0] ra [NB];
        logic [1:0]  ly [NB];
    } cfg_t;

    int checks = 0;
    int errors = 0;

    cfg_t         m_sh;        // model shadow settings
    cfg_t         cur_active;  // settings the outputs must currently show
    cfg_t         swap_q[$];   // snapshots taken at each accepted COMMIT
    logic [19:0]  wr_q[$];     // {address, data} of each expected BRAM write
    bit           m_rect, m_rect_ok;
    int           m_rect_idx;
    int           m_left;
    logic [AW-1:0] m_ptr;
    bit           m_err;
    bit           prev_cp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cfg_t zero_cfg();
        cfg_t c;
        c.bg = '0;
        c.en = '0;
        for (int i = 0; i < NB; i++) begin
            c.y1[i] = '0; c.x1[i] = '0; c.y2[i] = '0; c.x2[i] = '0;
            c.ra[i] = '0; c.ly[i] = '0;
        end
        return c;
    endfunction

    task automatic compare_active(input string tag, input cfg_t c);
        logic [10*NB-1:0] ey1, ex1, ey2, ex2;
        logic [AW*NB-1:0] era;
        logic [2*NB-1:0]  ely;
        for (int i = 0; i < NB; i++) begin
            ey1[i*10 +: 10] = c.y1[i];
            ex1[i*10 +: 10] = c.x1[i];
            ey2[i*10 +: 10] = c.y2[i];
            ex2[i*10 +: 10] = c.x2[i];
            era[i*AW +: AW] = c.ra[i];
            ely[i*2 +: 2]   = c.ly[i];
        end
        check({tag, ".background"}, 64'(background), 64'(c.bg));
        check({tag, ".sprite_enable"}, 64'(sprite_enable), 64'(c.en));
        check({tag, ".y1_pos"}, 64'(y1_pos), 64'(ey1));
        check({tag, ".x1_pos"}, 64'(x1_pos), 64'(ex1));
        check({tag, ".y2_pos"}, 64'(y2_pos), 64'(ey2));
        check({tag, ".x2_pos"}, 64'(x2_pos), 64'(ex2));
        check({tag, ".ram_address"}, 64'(ram_address), 64'(era));
        check({tag, ".layer"}, 64'(layer), 64'(ely));
    endtask

    task automatic model_reset();
        m_sh       = zero_cfg();
        cur_active = zero_cfg();
        swap_q.delete();
        wr_q.delete();
        m_rect = 0; m_rect_ok = 0; m_rect_idx = 0;
        m_left = 0; m_ptr = '0; m_err = 0;
    endtask

    // Word-level interpretation of the command protocol.
    task automatic model_accept(input logic [31:0] w, input bit clr);
        bit set = 0;
        int idx = int'(w[27:24]);
        if (m_rect) begin
            if (m_rect_ok) begin
                m_sh.y2[m_rect_idx] = w[19:10];
                m_sh.x2[m_rect_idx] = w[9:0];
            end
            m_rect = 0;
        end else if (m_left > 0) begin
            wr_q.push_back({m_ptr, w[11:0]});
            m_ptr  = m_ptr + 1'b1;
            m_left = m_left - 1;
        end else begin
            case (w[31:28])
                4'h1: m_sh.bg = w[11:0];
                4'h2: begin
                    m_rect = 1; m_rect_idx = idx; m_rect_ok = (idx < NB);
                    if (idx < NB) begin
                        m_sh.y1[idx] = w[19:10];
                        m_sh.x1[idx] = w[9:0];
                    end else set = 1;
                end
                4'h3: begin
                    if (idx < NB) begin
                        m_sh.en[idx] = w[23];
                        m_sh.ly[idx] = w[21:20];
                        m_sh.ra[idx] = w[AW-1:0];
                    end else set = 1;
                end
                4'h4: begin
                    m_left = int'(w[27:16]);
                    m_ptr  = w[AW-1:0];
                end
                4'h5: swap_q.push_back(m_sh);
                default: set = 1;
            endcase
        end
        if (set) m_err = 1;
        else if (clr) m_err = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the word has transferred.
    task automatic send_word(input logic [31:0] w, input bit clr, input bit vs);
        int n = 0;
        cmd_data  = w;
        cmd_valid = 1'b1;
        err_clr   = clr;
        v_sync    = vs;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            check("ready_timeout", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
            err_clr   = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(w, clr);
        #1;
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        check("err", 64'(err), 64'(m_err));
    endtask

    task automatic do_commit(input bit same_cycle_fb);
        if (!same_cycle_fb) begin
            send_word(32'h5000_0000, 0, 1);
            check("commit.ready_low", 64'(cmd_ready), 64'd0);
            check("commit.pending", 64'(commit_pending), 64'd1);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            check("commit.still_waiting", 64'(cmd_ready), 64'd0);
        end else begin
            v_sync = 1'b1;
            @(posedge clk); #1;
            send_word(32'h5000_0000, 0, 0);
            check("commit_fb_same.pending", 64'(commit_pending), 64'd1);
            v_sync = 1'b1;
            @(posedge clk); #1;
            check("commit_fb_same.pending2", 64'(commit_pending), 64'd1);
        end
        v_sync = 1'b0;
        @(posedge clk); #1;
        check("swap.pending_clear", 64'(commit_pending), 64'd0);
        check("swap.ready", 64'(cmd_ready), 64'd1);
        v_sync = 1'b1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        model_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        check("rst.wr_req", 64'(wr_req), 64'd0);
        check("rst.cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst.commit_pending", 64'(commit_pending), 64'd0);
        check("rst.err", 64'(err), 64'd0);
        compare_active("rst", cur_active);
    endtask

    // Scoreboard monitor: BRAM writes and shadow->active swaps.
    always @(negedge clk) begin
        logic [19:0] e;
        if (wr_req) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 64'(wr_req), 64'd0);
            end else begin
                e = wr_q.pop_front();
                check("wr_add", 64'(wr_add), 64'(e[19:12]));
                check("wr_data", 64'(wr_data), 64'(e[11:0]));
            end
        end
        if (reset) begin
            if (prev_cp && !commit_pending) begin
                if (swap_q.size() == 0) check("swap_unexpected", 64'd1, 64'd0);
                else cur_active = swap_q.pop_front();
            end
            compare_active("active", cur_active);
        end
        prev_cp = commit_pending;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // Background + attribute, committed on a later frame boundary
        send_word(32'h1000_0ABC, 0, 1);
        send_word(32'h3180_0005, 0, 1);
        do_commit(0);
        @(negedge clk);
        check("t1.background", 64'(background), 64'h0ABC);
        check("t1.enable1", 64'(sprite_enable[1]), 64'd1);
        check("t1.ram_address1", 64'(ram_address[15:8]), 64'd5);
        check("t1.layer1", 64'(layer[3:2]), 64'd0);
        @(posedge clk); #1;

        // Burst crossing the address wrap
        send_word(32'h4003_00FE, 0, 1);
        send_word(32'h0000_0111, 0, 1);
        send_word(32'h0000_0222, 0, 1);
        send_word(32'h0000_0333, 0, 1);
        @(posedge clk); #1;

        // Rectangle for blob 2
        send_word(32'h2200_2805, 0, 1);
        send_word(32'h0006_4C80, 0, 1);
        do_commit(0);
        @(negedge clk);
        check("t3.y1_2", 64'(y1_pos[29:20]), 64'd10);
        check("t3.x1_2", 64'(x1_pos[29:20]), 64'd5);
        check("t3.y2_2", 64'(y2_pos[29:20]), 64'd403);
        check("t3.x2_2", 64'(x2_pos[29:20]), 64'd128);
        @(posedge clk); #1;

        // Out-of-range index and illegal opcode, then error clear
        send_word(32'h34B0_0077, 0, 1);
        send_word(32'hF000_0000, 0, 1);
        check("t4.err_set", 64'(err), 64'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_err = 0;
        check("t4.err_clear", 64'(err), 64'd0);
        do_commit(0);

        // COMMIT coinciding with a frame boundary waits for the next one
        send_word(32'h1000_0123, 0, 1);
        do_commit(1);

        // Reset in the middle of a burst
        send_word(32'h4004_0010, 0, 1);
        send_word(32'h0000_0AAA, 0, 1);
        cmd_data  = 32'h0000_0BBB;
        cmd_valid = 1'b1;
        apply_reset();
        send_word(32'h1000_0555, 0, 1);
        do_commit(0);

        // Randomised command mix
        for (int k = 0; k < 300; k++) begin
            int sel = $urandom_range(0, 7);
            bit vs  = ($urandom_range(0, 3) != 0);
            logic [31:0] r = $urandom;
            case (sel)
                0: send_word({4'h1, r[27:0]}, 0, vs);
                1: begin
                    send_word({4'h2, 4'($urandom_range(0, 5)), r[23:0]}, 0, vs);
                    send_word($urandom, 0, vs);
                end
                2: send_word({4'h3, 4'($urandom_range(0, 5)), r[23:0]}, 0, vs);
                3: begin
                    int n = $urandom_range(0, 4);
                    send_word({4'h4, 12'(n), r[15:0]}, 0, vs);
                    for (int j = 0; j < n; j++) send_word($urandom, 0, vs);
                end
                4: send_word({4'($urandom_range(6, 15)), r[27:0]}, 0, vs);
                5: do_commit($urandom_range(0, 3) == 0);
                6: send_word({4'h1, r[27:0]}, 1, vs);
                default: send_word({4'h0, r[27:0]}, 0, vs);
            endcase
        end
        do_commit(0);
        repeat (3) @(posedge clk);
        #1;
        check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        check("swap_queue_drained", 64'(swap_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
